life_engine: RTL and testbench
==============================

LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 X, default 8, grid width in cells (columns, x index).
REQ-002 Y, default 8, grid height in cells (rows, y index).
REQ-003 LOG2X, default 3, width of x indices; LOG2Y, default 3, width of y indices.
REQ-004 BIRTH, default 9'b000001000, bit n set = dead cell with n live neighbours becomes alive.
REQ-005 SURVIVE, default 9'b000001100, bit n set = live cell with n live neighbours stays alive.
REQ-006 One clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 reset  input  1  asynchronous active-high reset.
REQ-009 step  input  1  request one generation; sampled only in IDLE.
REQ-010 run  input  1  level; generations computed back-to-back while high.
REQ-011 key_flip  input  1  toggle the cell at the cursor.
REQ-012 cursor_x  input  LOG2X  x of the flip target.
REQ-013 cursor_y  input  LOG2Y  y of the flip target.
REQ-014 disp_y  input  LOG2Y  row selected for display.
REQ-015 row  output  X  current-grid row disp_y, bit i = cell (i,disp_y); combinational.
REQ-016 busy  output  1  high in SCAN and COMMIT.
REQ-017 gen_done  output  1  one-cycle pulse, high while in COMMIT.
REQ-018 gen_count  output  16  completed generations, wraps 0xFFFF->0.
REQ-019 alive  output  1  OR of all current-grid cells; combinational.

Function
REQ-020 Storage: current grid cur[X*Y] and next grid nxt[X*Y]; cell index = y*X+x.
REQ-021 FSM states IDLE, SCAN, COMMIT; reset state IDLE.
REQ-022 IDLE->SCAN when (step|run) and no pending flip; scan counter set to 0.
REQ-023 SCAN: one cell per cycle, index 0..X*Y-1; nxt[i] = cur[i] ? SURVIVE[n] : BIRTH[n], n = 4-bit live-neighbour count 0..8.
REQ-024 SCAN->COMMIT after index X*Y-1; COMMIT->IDLE unconditionally after one cycle.
REQ-025 At the edge leaving COMMIT: cur <= nxt, gen_count increments.
REQ-026 Latency: step sampled at edge E; gen_done high in cycle X*Y+1 after E; new grid visible on row after the following edge.
REQ-027 cur is never modified during SCAN except by nothing; all neighbour reads use the pre-scan grid.
REQ-028 key_flip in IDLE: cur cell (cursor_x,cursor_y) toggles at the next edge.
REQ-029 key_flip with step/run in the same IDLE cycle: flip applied at the same edge the FSM enters SCAN; scan sees flipped cell.
REQ-030 key_flip while busy: cursor captured, pending flag set; applied at first IDLE cycle; pending flip blocks IDLE->SCAN for that one cycle.
REQ-031 Further key_flip while a flip is pending: ignored.
REQ-032 cursor_x>=X or cursor_y>=Y: flip ignored, no pending set.
REQ-033 disp_y>=Y: row = all zeros.
REQ-034 step while busy: ignored, not queued.

Reset
REQ-035 Reset (any time, incl. mid-SCAN): state IDLE, cur and nxt all zero, scan counter 0, gen_count 0, pending flag clear.
REQ-036 Output values during/after reset: busy=0, gen_done=0, gen_count=0, alive=0, row=0.

Configuration
REQ-037 Macro LIFE_WRAP_EN defined: toroidal grid, neighbour coordinates taken modulo X and Y.
REQ-038 LIFE_WRAP_EN undefined: cells outside the grid count as dead (fixed dead border); default build.

Verification (X=Y=8, default rules)
REQ-039 Flip (2,3),(3,3),(4,3); step -> gen_done 65 cycles after step edge; then rows 2,3,4 = 8'h08, others 0, gen_count=1.
REQ-040 Without LIFE_WRAP_EN: flip (7,3),(0,3),(1,3); step -> all rows 0, alive=0. With LIFE_WRAP_EN: rows 2,3,4 = 8'h01, alive=1.
REQ-041 Block (1,1),(2,1),(1,2),(2,2); run high 5 generations -> grid unchanged, gen_count=5, gen_done pulsed 5 times, single idle cycle between scans.
REQ-042 key_flip at (5,5) during SCAN, second key_flip at (6,6) during same SCAN -> after COMMIT, next IDLE cycle toggles (5,5) only; run restart delayed one cycle.
REQ-043 Reset asserted at scan index 30 -> immediately busy=0, alive=0, gen_count=0; after release, step on empty grid -> grid stays empty, gen_count=1.
REQ-044 cursor_x=9 with X=8 parameterised as X=9? no: X=6,Y=6 instance, cursor_x=7 flip -> no change; disp_y=6 -> row=0.

Source files
------------

// File: rtl/life_engine.sv
//==============================================================================
// life_engine : Game-of-Life generation engine, one cell per clock per scan.
// Optional LIFE_WRAP_EN macro selects a toroidal grid instead of a dead border.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module life_engine #(
  parameter int         X       = 8,
  parameter int         Y       = 8,
  parameter int         LOG2X   = 3,
  parameter int         LOG2Y   = 3,
  parameter logic [8:0] BIRTH   = 9'b000001000,
  parameter logic [8:0] SURVIVE = 9'b000001100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             run,
  input  logic             key_flip,
  input  logic [LOG2X-1:0] cursor_x,
  input  logic [LOG2Y-1:0] cursor_y,
  input  logic [LOG2Y-1:0] disp_y,
  output logic [X-1:0]     row,
  output logic             busy,
  output logic             gen_done,
  output logic [15:0]      gen_count,
  output logic             alive
);

  localparam int N  = X * Y;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       cur_q, cur_d;
  logic [N-1:0]       nxt_q, nxt_d;
  logic [LOG2X-1:0]   sx_q, sx_d;
  logic [LOG2Y-1:0]   sy_q, sy_d;
  logic [15:0]        gen_q, gen_d;
  logic               pend_q, pend_d;
  logic [LOG2X-1:0]   px_q, px_d;
  logic [LOG2Y-1:0]   py_q, py_d;

  logic [CW-1:0]      scan_idx;
  logic [CW-1:0]      flip_idx;
  logic [CW-1:0]      pend_idx;
  logic               flip_ok;
  logic [3:0]         nbr_cnt;
  logic               new_cell;

  always_comb begin
    scan_idx = CW'(int'(sy_q) * X + int'(sx_q));
    flip_idx = CW'(int'(cursor_y) * X + int'(cursor_x));
    pend_idx = CW'(int'(py_q) * X + int'(px_q));
    flip_ok  = key_flip && (int'(cursor_x) < X) && (int'(cursor_y) < Y);
  end

  // Live-neighbour count of the cell under the scan pointer, read from cur only.
  always_comb begin
    int nx;
    int ny;
    nbr_cnt = 4'd0;
    nx      = 0;
    ny      = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(sx_q) + dx;
        ny = int'(sy_q) + dy;
`ifdef LIFE_WRAP_EN
        nx = (nx + X) % X;
        ny = (ny + Y) % Y;
        if (!(dx == 0 && dy == 0)) begin
          nbr_cnt = nbr_cnt + {3'b000, cur_q[CW'(ny * X + nx)]};
        end
`else
        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < X && ny >= 0 && ny < Y) begin
          nbr_cnt = nbr_cnt + {3'b000, cur_q[CW'(ny * X + nx)]};
        end
`endif
      end
    end
    new_cell = cur_q[scan_idx] ? SURVIVE[nbr_cnt] : BIRTH[nbr_cnt];
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    gen_d   = gen_q;
    pend_d  = pend_q;
    px_d    = px_q;
    py_d    = py_q;

    case (state_q)
      IDLE: begin
        // A deferred flip owns this idle cycle; the scan starts one cycle later.
        if (pend_q) begin
          cur_d[pend_idx] = ~cur_q[pend_idx];
          pend_d          = 1'b0;
        end else begin
          if (flip_ok) begin
            cur_d[flip_idx] = ~cur_q[flip_idx];
          end
          if (step || run) begin
            state_d = SCAN;
            sx_d    = '0;
            sy_d    = '0;
          end
        end
      end
      SCAN: begin
        nxt_d[scan_idx] = new_cell;
        if (int'(sx_q) == X - 1) begin
          sx_d = '0;
          sy_d = sy_q + 1'b1;
        end else begin
          sx_d = sx_q + 1'b1;
        end
        if (scan_idx == CW'(N - 1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        cur_d   = nxt_q;
        gen_d   = gen_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && flip_ok && !pend_q) begin
      pend_d = 1'b1;
      px_d   = cursor_x;
      py_d   = cursor_y;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      nxt_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      gen_q   <= '0;
      pend_q  <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      gen_q   <= gen_d;
      pend_q  <= pend_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  always_comb begin
    row = '0;
    if (int'(disp_y) < Y) begin
      for (int i = 0; i < X; i++) begin
        row[i] = cur_q[CW'(int'(disp_y) * X + i)];
      end
    end
    busy      = (state_q != IDLE);
    gen_done  = (state_q == COMMIT);
    gen_count = gen_q;
    alive     = |cur_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_life_engine.sv
//==============================================================================
// tb_life_engine : directed self-checking bench for life_engine (8x8 and 6x6).
// Revision       : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_life_engine;

  logic        clk;
  logic        reset;
  logic        step;
  logic        run;
  logic        key_flip;
  logic [2:0]  cx;
  logic [2:0]  cy;
  logic [2:0]  dy;
  logic [7:0]  row8;
  logic        busy;
  logic        gen_done;
  logic [15:0] gen_count;
  logic        alive;

  logic        step6;
  logic        run6;
  logic        kf6;
  logic [2:0]  cx6;
  logic [2:0]  cy6;
  logic [2:0]  dy6;
  logic [5:0]  row6;
  logic        busy6;
  logic        gd6;
  logic [15:0] gc6;
  logic        alive6;

  int n_tests = 0;
  int n_fail  = 0;

  life_engine u_dut (
    .clk(clk), .reset(reset), .step(step), .run(run), .key_flip(key_flip),
    .cursor_x(cx), .cursor_y(cy), .disp_y(dy), .row(row8), .busy(busy),
    .gen_done(gen_done), .gen_count(gen_count), .alive(alive)
  );

  life_engine #(.X(6), .Y(6), .LOG2X(3), .LOG2Y(3)) u_dut6 (
    .clk(clk), .reset(reset), .step(step6), .run(run6), .key_flip(kf6),
    .cursor_x(cx6), .cursor_y(cy6), .disp_y(dy6), .row(row6), .busy(busy6),
    .gen_done(gd6), .gen_count(gc6), .alive(alive6)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic flip(input logic [2:0] x, input logic [2:0] y);
    cx       = x;
    cy       = y;
    key_flip = 1'b1;
    tick();
    key_flip = 1'b0;
  endtask

  // Returns the cycle (counted from the step edge) in which gen_done was seen,
  // then advances one edge so the new grid is visible.
  task automatic step_gen(output int lat);
    step = 1'b1;
    tick();
    step = 1'b0;
    lat  = 1;
    while (!gen_done && lat < 300) begin
      tick();
      lat++;
    end
    tick();
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (!gen_done && c < 300) begin
      tick();
      c++;
    end
    check(tag, {63'd0, gen_done}, 64'd1);
  endtask

  task automatic check_grid(input string tag, input logic [63:0] exp);
    for (int y = 0; y < 8; y++) begin
      dy = 3'(y);
      #1;
      check($sformatf("%s_row%0d", tag, y), {56'd0, row8}, {56'd0, exp[y*8 +: 8]});
    end
    dy = 3'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int pulses;
    int idles;
    int cyc;

    reset = 1'b1; step = 1'b0; run = 1'b0; key_flip = 1'b0;
    cx = 3'd0; cy = 3'd0; dy = 3'd0;
    step6 = 1'b0; run6 = 1'b0; kf6 = 1'b0; cx6 = 3'd0; cy6 = 3'd0; dy6 = 3'd0;

    // Reset values, observed while reset is held
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_gen_done", {63'd0, gen_done}, 64'd0);
    check("rst_gen_count", {48'd0, gen_count}, 64'd0);
    check("rst_alive", {63'd0, alive}, 64'd0);
    check("rst_row", {56'd0, row8}, 64'd0);
    reset = 1'b0;
    tick();

    // Horizontal blinker becomes vertical
    flip(3'd2, 3'd3); flip(3'd3, 3'd3); flip(3'd4, 3'd3);
    step_gen(lat);
    check("blink_latency", 64'(lat), 64'd65);
    check_grid("blink", 64'h00000008_08080000);
    check("blink_gen_count", {48'd0, gen_count}, 64'd1);

    // Blinker straddling the x edge
    do_reset();
    flip(3'd7, 3'd3); flip(3'd0, 3'd3); flip(3'd1, 3'd3);
    step_gen(lat);
`ifdef LIFE_WRAP_EN
    check_grid("edge", 64'h00000001_01010000);
    check("edge_alive", {63'd0, alive}, 64'd1);
`else
    check_grid("edge", 64'h0);
    check("edge_alive", {63'd0, alive}, 64'd0);
`endif

    // Still-life block under continuous run for 5 generations
    do_reset();
    flip(3'd1, 3'd1); flip(3'd2, 3'd1); flip(3'd1, 3'd2); flip(3'd2, 3'd2);
    run    = 1'b1;
    pulses = 0;
    idles  = 0;
    cyc    = 0;
    while (pulses < 5 && cyc < 1000) begin
      tick();
      cyc++;
      if (gen_done) pulses++;
      else if (!busy) idles++;
    end
    run = 1'b0;
    tick();
    tick();
    check("block_pulses", 64'(pulses), 64'd5);
    check("block_idle_gaps", 64'(idles), 64'd4);
    check("block_busy", {63'd0, busy}, 64'd0);
    check("block_gen_count", {48'd0, gen_count}, 64'd5);
    check_grid("block", 64'h00000000_00060600);

    // Flips while busy: first is deferred, second is dropped
    do_reset();
    run = 1'b1;
    tick();
    repeat (3) tick();
    flip(3'd5, 3'd5);
    flip(3'd6, 3'd6);
    wait_done("pend_commit");
    tick();
    check("pend_idle1_busy", {63'd0, busy}, 64'd0);
    check("pend_idle1_alive", {63'd0, alive}, 64'd0);
    tick();
    check("pend_idle2_busy", {63'd0, busy}, 64'd0);
    check("pend_idle2_alive", {63'd0, alive}, 64'd1);
    check("pend_gen_count", {48'd0, gen_count}, 64'd1);
    dy = 3'd5;
    #1;
    check("pend_row5", {56'd0, row8}, 64'h20);
    dy = 3'd6;
    #1;
    check("pend_row6", {56'd0, row8}, 64'h00);
    dy = 3'd0;
    tick();
    check("pend_restart_busy", {63'd0, busy}, 64'd1);
    run = 1'b0;
    wait_done("pend_second_commit");
    tick();
    check("pend_lone_cell_dies", {63'd0, alive}, 64'd0);

    // Step ignored while busy, then reset mid-scan at index 30
    do_reset();
    flip(3'd2, 3'd3); flip(3'd3, 3'd3); flip(3'd4, 3'd3);
    step_gen(lat);
    step = 1'b1;
    tick();
    repeat (30) tick();
    check("mid_busy", {63'd0, busy}, 64'd1);
    check("mid_step_ignored_gen", {48'd0, gen_count}, 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_alive", {63'd0, alive}, 64'd0);
    check("mid_rst_gen_count", {48'd0, gen_count}, 64'd0);
    check("mid_rst_gen_done", {63'd0, gen_done}, 64'd0);
    #1;
    reset = 1'b0;
    step  = 1'b0;
    tick();
    step_gen(lat);
    check("empty_gen_count", {48'd0, gen_count}, 64'd1);
    check("empty_alive", {63'd0, alive}, 64'd0);

    // 6x6 instance: out-of-range cursor and out-of-range display row
    do_reset();
    cx6 = 3'd7; cy6 = 3'd2; kf6 = 1'b1;
    tick();
    kf6 = 1'b0;
    tick();
    check("g6_bad_cursor_alive", {63'd0, alive6}, 64'd0);
    check("g6_bad_cursor_busy", {63'd0, busy6}, 64'd0);
    cx6 = 3'd5; cy6 = 3'd5; kf6 = 1'b1;
    tick();
    kf6 = 1'b0;
    check("g6_flip_alive", {63'd0, alive6}, 64'd1);
    dy6 = 3'd5;
    #1;
    check("g6_row5", {58'd0, row6}, 64'h20);
    dy6 = 3'd6;
    #1;
    check("g6_row_oob", {58'd0, row6}, 64'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
